// File: rtl/debounce_multi.sv
// Multi-channel button debouncer with press, release and long-press events.
// Ports: clk, rst (sync, active-high), btn_in[N_CH] raw levels;
//   btn_level, press_pulse, release_pulse, long_pulse per channel;
//   any_pressed = registered OR of btn_level.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int LONG_CYCLES   = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic            any_pressed
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG,
        RELEASE_WAIT
    } state_t;

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] btn_s;
    logic [N_CH-1:0] lvl_nv;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            btn_s       <= '0;
            any_pressed <= 1'b0;
        end else begin
            sync1       <= btn_in;
            btn_s       <= sync1;
            // Built from next-state levels so it tracks btn_level exactly.
            any_pressed <= |lvl_nv;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        st, st_n;
        logic [SW-1:0] sc, sc_n;
        logic [HW-1:0] hc, hc_n;
        logic          org, org_n;
        logic          lvl, lvl_n;
        logic          pp, pp_n;
        logic          rp, rp_n;
        logic          lp, lp_n;
        logic          s;

        assign s = btn_s[i];

        always_comb begin
            st_n  = st;
            sc_n  = sc;
            hc_n  = hc;
            org_n = org;
            lvl_n = lvl;
            pp_n  = 1'b0;
            rp_n  = 1'b0;
            lp_n  = 1'b0;
            unique case (st)
                IDLE: begin
                    if (s) begin
                        if (STABLE_CYCLES == 1) begin
                            st_n  = PRESSED;
                            lvl_n = 1'b1;
                            pp_n  = 1'b1;
                            hc_n  = '0;
                            sc_n  = '0;
                        end else begin
                            st_n = PRESS_WAIT;
                            sc_n = S_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        st_n = IDLE;
                        sc_n = '0;
                    end else if (sc >= S_LAST) begin
                        st_n  = PRESSED;
                        lvl_n = 1'b1;
                        pp_n  = 1'b1;
                        hc_n  = '0;
                        sc_n  = '0;
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                PRESSED, LONG: begin
                    if (!s) begin
                        if (STABLE_CYCLES == 1) begin
                            st_n  = IDLE;
                            lvl_n = 1'b0;
                            rp_n  = 1'b1;
                            sc_n  = '0;
                            org_n = 1'b0;
                        end else begin
                            st_n  = RELEASE_WAIT;
                            sc_n  = S_ONE;
                            org_n = (st == LONG);
                        end
                    end else if (st == PRESSED) begin
                        if (hc >= H_LAST) begin
                            st_n = LONG;
                            hc_n = H_MAX;
                            lp_n = 1'b1;
                        end else begin
                            hc_n = hc + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        // Bounce back: resume origin; hold count
                        // counts this high cycle again.
                        sc_n = '0;
                        if (org) begin
                            st_n = LONG;
                        end else if (hc >= H_LAST) begin
                            st_n = LONG;
                            hc_n = H_MAX;
                            lp_n = 1'b1;
                        end else begin
                            st_n = PRESSED;
                            hc_n = hc + 1'b1;
                        end
                    end else if (sc >= S_LAST) begin
                        st_n  = IDLE;
                        lvl_n = 1'b0;
                        rp_n  = 1'b1;
                        sc_n  = '0;
                        org_n = 1'b0;
                    end else begin
                        sc_n = sc + 1'b1;
                    end
                end
                default: begin
                    st_n = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= IDLE;
                sc  <= '0;
                hc  <= '0;
                org <= 1'b0;
                lvl <= 1'b0;
                pp  <= 1'b0;
                rp  <= 1'b0;
                lp  <= 1'b0;
            end else begin
                st  <= st_n;
                sc  <= sc_n;
                hc  <= hc_n;
                org <= org_n;
                lvl <= lvl_n;
                pp  <= pp_n;
                rp  <= rp_n;
                lp  <= lp_n;
            end
        end

        assign lvl_nv[i]        = lvl_n;
        assign btn_level[i]     = lvl;
        assign press_pulse[i]   = pp;
        assign release_pulse[i] = rp;
        assign long_pulse[i]    = lp;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi with default parameters.
// Stimulus queues expected pulse events; a monitor pops and compares.
module tb_debounce_multi;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] long_pulse;
    logic       any_pressed;

    debounce_multi dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .any_pressed  (any_pressed)
    );

    typedef struct {
        int         e;
        logic [3:0] pp;
        logic [3:0] rp;
        logic [3:0] lp;
        logic [3:0] lvl;
        logic       any;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  edge_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic push(input int e, input logic [3:0] pp,
                        input logic [3:0] rp, input logic [3:0] lp,
                        input logic [3:0] lvl);
        ev_t x;
        x.e   = e;
        x.pp  = pp;
        x.rp  = rp;
        x.lp  = lp;
        x.lvl = lvl;
        x.any = |lvl;
        q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [16:0] outs();
        return {any_pressed, btn_level, press_pulse,
                release_pulse, long_pulse};
    endfunction

    // Monitor: any pulse must match the next queued event.
    always @(negedge clk) begin
        ev_t x;
        if ((press_pulse | release_pulse | long_pulse) != 4'b0) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: edge=%0d outs=%h required=none",
                         edge_cnt, outs());
            end else begin
                x = q.pop_front();
                chk("event_edge", 17'(edge_cnt), 17'(x.e));
                chk("event_outs", outs(),
                    {x.any, x.lvl, x.pp, x.rp, x.lp});
            end
        end
    end

    int k;

    initial begin
        rst    = 1'b1;
        btn_in = 4'b0;
        idle(3);
        chk("reset_outs", outs(), 17'h0);
        rst = 1'b0;
        idle(2);
        chk("idle_outs", outs(), 17'h0);

        // Clean press and release on ch0.
        k = edge_cnt;
        btn_in[0] = 1'b1;
        push(k + 6, 4'b0001, 4'b0, 4'b0, 4'b0001);
        idle(5);
        chk("ch0_not_yet", 17'(btn_level), 17'h0);
        idle(5);
        chk("ch0_level", 17'({any_pressed, btn_level}), 17'h11);
        k = edge_cnt;
        btn_in[0] = 1'b0;
        push(k + 6, 4'b0, 4'b0001, 4'b0, 4'b0000);
        idle(10);
        chk("ch0_released", 17'({any_pressed, btn_level}), 17'h0);

        // Bounce on ch1: high 3, low 1, high 10.
        k = edge_cnt;
        btn_in[1] = 1'b1;
        idle(3);
        btn_in[1] = 1'b0;
        idle(1);
        btn_in[1] = 1'b1;
        push(k + 10, 4'b0010, 4'b0, 4'b0, 4'b0010);
        idle(5);
        chk("ch1_bounce_hold", 17'(btn_level), 17'h0);
        idle(5);
        k = edge_cnt;
        btn_in[1] = 1'b0;
        push(k + 6, 4'b0, 4'b0010, 4'b0, 4'b0000);
        idle(10);

        // Long press on ch2.
        k = edge_cnt;
        btn_in[2] = 1'b1;
        push(k + 6, 4'b0100, 4'b0, 4'b0, 4'b0100);
        push(k + 106, 4'b0, 4'b0, 4'b0100, 4'b0100);
        idle(120);
        btn_in[2] = 1'b0;
        push(k + 126, 4'b0, 4'b0100, 4'b0, 4'b0000);
        idle(10);

        // Release bounce on ch0 shifts long by two frozen cycles.
        k = edge_cnt;
        btn_in[0] = 1'b1;
        push(k + 6, 4'b0001, 4'b0, 4'b0, 4'b0001);
        idle(10);
        btn_in[0] = 1'b0;
        idle(2);
        btn_in[0] = 1'b1;
        idle(4);
        chk("ch0_rel_bounce_lvl", 17'(btn_level), 17'h1);
        push(k + 108, 4'b0, 4'b0, 4'b0001, 4'b0001);
        idle(99);
        btn_in[0] = 1'b0;
        push(k + 121, 4'b0, 4'b0001, 4'b0, 4'b0000);
        idle(10);

        // Reset mid-press on ch3.
        k = edge_cnt;
        btn_in[3] = 1'b1;
        push(k + 6, 4'b1000, 4'b0, 4'b0, 4'b1000);
        idle(56);
        rst = 1'b1;
        idle(1);
        chk("mid_reset_outs", outs(), 17'h0);
        rst = 1'b0;
        push(k + 63, 4'b1000, 4'b0, 4'b0, 4'b1000);
        idle(5);
        chk("requal_not_yet", 17'(btn_level), 17'h0);
        idle(58);
        btn_in[3] = 1'b0;
        push(k + 126, 4'b0, 4'b1000, 4'b0, 4'b0000);
        idle(10);

        // All four channels together.
        k = edge_cnt;
        btn_in = 4'b1111;
        push(k + 6, 4'b1111, 4'b0, 4'b0, 4'b1111);
        idle(10);
        btn_in = 4'b0000;
        push(k + 16, 4'b0, 4'b1111, 4'b0, 4'b0000);
        idle(12);

        chk("queue_drained", 17'(q.size()), 17'h0);
        chk("final_outs", outs(), 17'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
